// File: rtl/booth4_pkg.sv
// -----------------------------------------------------------------------------
// booth4_pkg
// Shared definitions for the radix-4 Booth sequential multiplier:
//   - state_t    : controller states (IDLE, RUN)
//   - INV/SEL2/SEL1 : bit positions inside a 3-bit recode digit {inv, sel2, sel1}
// -----------------------------------------------------------------------------
package booth4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Recode digit field indices
    localparam int INV  = 2;
    localparam int SEL2 = 1;
    localparam int SEL1 = 0;

    localparam int DIGIT_W = 3;

endpackage : booth4_pkg

// File: rtl/booth4_seq_mult_recode.sv
// -----------------------------------------------------------------------------
// booth4_seq_mult_recode
// Combinational radix-4 Booth recoder. Maps a 3-bit multiplier window
// {b[2i+1], b[2i], b[2i-1]} onto a digit {inv, sel2, sel1}:
//   000/111 -> 000 (0)      001/010 -> 001 (+A)     011 -> 010 (+2A)
//   100     -> 110 (-2A)    101/110 -> 101 (-A)
// Ports:
//   bits_i  [2:0]  multiplier window, LSB is the previously consumed bit
//   digit_o [2:0]  recode digit, fields indexed by INV/SEL2/SEL1
// -----------------------------------------------------------------------------
module booth4_seq_mult_recode
    import booth4_pkg::*;
(
    input  logic [2:0]         bits_i,
    output logic [DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = '0;
        unique case (bits_i)
            3'b000, 3'b111: digit_o = 3'b000;
            3'b001, 3'b010: digit_o = 3'b001;
            3'b011:         digit_o = 3'b010;
            3'b100:         digit_o = 3'b110;
            3'b101, 3'b110: digit_o = 3'b101;
            default:        digit_o = 3'b000;
        endcase
    end

endmodule : booth4_seq_mult_recode

// File: rtl/booth4_seq_mult.sv
// -----------------------------------------------------------------------------
// booth4_seq_mult
// Sequential radix-4 Booth multiplier. Accepts an N x N operand pair on a
// start pulse (sampled only in IDLE), retires one recode digit per clock and
// returns the 2N-bit product with a one-cycle done pulse.
//
// Optional feature macro: BOOTH4_UNSIGNED_EN
//   defined   : adds port tc (1 = signed, 0 = unsigned, N/2+1 iterations)
//   undefined : always signed, N/2 iterations
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request (ignored while busy)
//   tc     in   two's-complement select (only with BOOTH4_UNSIGNED_EN)
//   a      in   [N-1:0]  multiplicand
//   b      in   [N-1:0]  multiplier
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse, p valid
//   p      out  [2N-1:0] product, held until the next completion
// -----------------------------------------------------------------------------
module booth4_seq_mult
    import booth4_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
`ifdef BOOTH4_UNSIGNED_EN
    input  logic           tc,
`endif
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int AW = N + 2;              // multiplicand, room for 2A
    localparam int PW = 2 * N;              // accumulator / product
    localparam int MW = N + 3;              // multiplier reg {ext, ext, b, 0}
    localparam int CW = $clog2(N / 2 + 1);  // counter holds up to N/2

    state_t         state_q, state_d;
    logic [AW-1:0]  a_q, a_d;
    logic [MW-1:0]  m_q, m_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  last_q, last_d;
    logic [PW-1:0]  p_q, p_d;
    logic           done_q, done_d;

    logic           signed_op;
    logic [DIGIT_W-1:0] digit;
    logic [AW-1:0]  pp_mag;
    logic [AW-1:0]  pp;
    logic [PW-1:0]  pp_ext;
    logic [PW-1:0]  pp_shift;
    logic [PW-1:0]  sum;

`ifdef BOOTH4_UNSIGNED_EN
    assign signed_op = tc;
`else
    assign signed_op = 1'b1;
`endif

    booth4_seq_mult_recode u_recode (
        .bits_i  (m_q[2:0]),
        .digit_o (digit)
    );

    // Partial product: select magnitude, then negate only a non-zero
    // selection so that a zero digit always contributes exactly 0.
    always_comb begin
        pp_mag = '0;
        if (digit[SEL1]) begin
            pp_mag = a_q;
        end else if (digit[SEL2]) begin
            pp_mag = {a_q[AW-2:0], 1'b0};
        end
        pp = pp_mag;
        if (digit[INV] && (digit[SEL1] || digit[SEL2])) begin
            pp = ~pp_mag + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    assign pp_ext   = {{(PW-AW){pp[AW-1]}}, pp};
    assign pp_shift = pp_ext << {cnt_q, 1'b0};
    assign sum      = acc_q + pp_shift;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        p_d     = p_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (signed_op) begin
                        a_d    = {{2{a[N-1]}}, a};
                        // Sign-extended copies of b keep the two unused top
                        // bits harmless; signed mode never reads them.
                        m_d    = {{2{b[N-1]}}, b, 1'b0};
                        last_d = CW'(N / 2 - 1);
                    end else begin
                        a_d    = {2'b00, a};
                        // The extra digit over {0, 0, b[N-1]} corrects for b's
                        // top bit being treated as a sign bit.
                        m_d    = {2'b00, b, 1'b0};
                        last_d = CW'(N / 2);
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                m_d   = m_q >> 2;
                if (cnt_q == last_q) begin
                    p_d     = sum;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign p    = p_q;

endmodule : booth4_seq_mult

// File: tb/tb_booth4_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_booth4_seq_mult
// Self-checking bench for booth4_seq_mult (N = 8). Products are compared
// against plain integer multiplication truncated to 16 bits.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_booth4_seq_mult;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           tc = 1'b1;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    int pass_cnt = 0;
    int total_cnt = 0;

    booth4_seq_mult #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef BOOTH4_UNSIGNED_EN
        .tc    (tc),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product, reduced modulo 2^16.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                            input logic is_signed);
        int r;
        if (is_signed) r = int'($signed(x)) * int'($signed(y));
        else           r = int'(x) * int'(y);
        return r[15:0];
    endfunction

    // Drives one operation starting right now (caller is just after an edge).
    // Returns the product seen at done, latency in cycles, and busy after accept.
    task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic otc,
                         output logic [15:0] op, output int lat, output logic busy_seen);
        a = oa; b = ob; tc = otc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_seen = busy;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        op = p;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else pass_cnt++;
        total_cnt++; if (p !== 16'h0) $display("FAIL reset_p got=%h exp=0000", p); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL post_reset_idle busy=%0b done=%0b exp=0/0", busy, done); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [7:0] va [4] = '{8'd3, 8'h80, 8'd127, 8'hFF};
        logic [7:0] vb [4] = '{8'd5, 8'h80, 8'h80, 8'd127};
        logic [15:0] ve [4] = '{16'h000F, 16'h4000, 16'hC080, 16'hFF81};
        logic [15:0] got; int lat; logic bz;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 1'b1, got, lat, bz);
            $display("op a=%h b=%h p=%h lat=%0d", va[i], vb[i], got, lat);
            total_cnt++; if (got !== ve[i]) $display("FAIL directed_p[%0d] got=%h exp=%h", i, got, ve[i]); else pass_cnt++;
            total_cnt++; if (lat !== 4) $display("FAIL directed_lat[%0d] got=%0d exp=4", i, lat); else pass_cnt++;
            total_cnt++; if (bz !== 1'b1) $display("FAIL directed_busy[%0d] got=%0b exp=1", i, bz); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (done !== 1'b0) $display("FAIL directed_pulse[%0d] done=%0b exp=0", i, done); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got; int lat; logic bz;
        do_op(8'd3, 8'd5, 1'b1, got, lat, bz);
        $display("op a=03 b=05 p=%h lat=%0d", got, lat);
        total_cnt++; if (got !== 16'h000F) $display("FAIL b2b_first_p got=%h exp=000F", got); else pass_cnt++;
        // Still inside the done cycle: next start must be accepted.
        do_op(8'hF9, 8'd9, 1'b1, got, lat, bz);
        $display("op a=f9 b=09 p=%h lat=%0d", got, lat);
        total_cnt++; if (got !== 16'hFFC1) $display("FAIL b2b_p got=%h exp=FFC1", got); else pass_cnt++;
        total_cnt++; if (lat !== 4) $display("FAIL b2b_lat got=%0d exp=4", lat); else pass_cnt++;
        total_cnt++; if (bz !== 1'b1) $display("FAIL b2b_busy got=%0b exp=1", bz); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int ndone = 0;
        int dcyc = -1;
        a = 8'd5; b = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin a = 8'd77; b = 8'd88; start = 1'b1; end
            if (i == 2) start = 1'b0;
            if (done) begin ndone++; if (dcyc < 0) dcyc = i; end
        end
        $display("op a=05 b=06 (start while busy) dones=%0d at=%0d p=%h", ndone, dcyc, p);
        total_cnt++; if (ndone !== 1) $display("FAIL ignore_ndone got=%0d exp=1", ndone); else pass_cnt++;
        total_cnt++; if (dcyc !== 4) $display("FAIL ignore_lat got=%0d exp=4", dcyc); else pass_cnt++;
        total_cnt++; if (p !== 16'd30) $display("FAIL ignore_p got=%h exp=001E", p); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ignore_busy got=%0b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_midrun_reset();
        logic [15:0] got; int lat; logic bz;
        int ndone = 0;
        a = 8'd100; b = 8'hFD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%0b exp=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL midrst_done got=%0b exp=0", done); else pass_cnt++;
        total_cnt++; if (p !== 16'h0) $display("FAIL midrst_p got=%h exp=0000", p); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        total_cnt++; if (ndone !== 0) $display("FAIL midrst_spurious_done got=%0d exp=0", ndone); else pass_cnt++;
        do_op(8'd2, 8'd2, 1'b1, got, lat, bz);
        $display("op a=02 b=02 after reset p=%h lat=%0d", got, lat);
        total_cnt++; if (got !== 16'h0004) $display("FAIL midrst_after_p got=%h exp=0004", got); else pass_cnt++;
        total_cnt++; if (lat !== 4) $display("FAIL midrst_after_lat got=%0d exp=4", lat); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [7:0] corners [6] = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F};
        logic [7:0] ra, rb;
        logic [15:0] got, exp; int lat; logic bz;
        for (int i = 0; i < 1536; i++) begin
            if (i < 36) begin
                ra = corners[i / 6]; rb = corners[i % 6];
            end else begin
                ra = 8'($urandom); rb = 8'($urandom);
            end
            exp = ref_mul(ra, rb, 1'b1);
            do_op(ra, rb, 1'b1, got, lat, bz);
            $display("op a=%h b=%h p=%h exp=%h lat=%0d", ra, rb, got, exp, lat);
            total_cnt++; if (got !== exp || lat !== 4 || bz !== 1'b1)
                $display("FAIL rand_op[%0d] a=%h b=%h p=%h exp=%h lat=%0d exp_lat=4 busy=%0b", i, ra, rb, got, exp, lat, bz);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (done !== 1'b0) $display("FAIL rand_pulse[%0d] done=%0b exp=0", i, done); else pass_cnt++;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
    endtask

`ifdef BOOTH4_UNSIGNED_EN
    task automatic test_unsigned();
        logic [7:0] ra, rb;
        logic [15:0] got, exp; int lat; logic bz; logic rtc;
        do_op(8'hFF, 8'hFF, 1'b0, got, lat, bz);
        $display("op u a=ff b=ff p=%h lat=%0d", got, lat);
        total_cnt++; if (got !== 16'hFE01) $display("FAIL uns_p got=%h exp=FE01", got); else pass_cnt++;
        total_cnt++; if (lat !== 5) $display("FAIL uns_lat got=%0d exp=5", lat); else pass_cnt++;
        do_op(8'hFF, 8'hFF, 1'b1, got, lat, bz);
        $display("op s a=ff b=ff p=%h lat=%0d", got, lat);
        total_cnt++; if (got !== 16'h0001) $display("FAIL tc1_p got=%h exp=0001", got); else pass_cnt++;
        total_cnt++; if (lat !== 4) $display("FAIL tc1_lat got=%0d exp=4", lat); else pass_cnt++;
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rtc = 1'($urandom);
            exp = ref_mul(ra, rb, rtc);
            do_op(ra, rb, rtc, got, lat, bz);
            $display("op tc=%0b a=%h b=%h p=%h exp=%h lat=%0d", rtc, ra, rb, got, exp, lat);
            total_cnt++; if (got !== exp || lat !== (rtc ? 4 : 5))
                $display("FAIL mixed_op[%0d] tc=%0b p=%h exp=%h lat=%0d", i, rtc, got, exp, lat);
            else pass_cnt++;
        end
        tc = 1'b1;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_ignore();
        test_midrun_reset();
        test_random();
`ifdef BOOTH4_UNSIGNED_EN
        test_unsigned();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_booth4_seq_mult
